// File: rtl/fht_ctrl_pkg.sv
// Shared types and butterfly address/twiddle formulas for the radix-2 FHT
// sequencer; the same functions are used by the RTL and the bench model.
package fht_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int unsigned but_x0(input int unsigned j, input int unsigned s);
    int unsigned h, blk, k;
    h   = 32'd1 << s;
    blk = j >> s;
    k   = j & (h - 32'd1);
    return blk * (h << 1) + k;
  endfunction

  function automatic int unsigned but_x1(input int unsigned j, input int unsigned s);
    int unsigned h, blk, k;
    h   = 32'd1 << s;
    blk = j >> s;
    k   = j & (h - 32'd1);
    return blk * (h << 1) + h + k;
  endfunction

  // Mirror partner of x0 inside the block; k=0 pairs with the block midpoint.
  function automatic int unsigned but_x2(input int unsigned j, input int unsigned s);
    int unsigned h, blk, k;
    h   = 32'd1 << s;
    blk = j >> s;
    k   = j & (h - 32'd1);
    if (k == 32'd0) return blk * (h << 1) + h;
    return blk * (h << 1) + (h << 1) - k;
  endfunction

  function automatic int unsigned but_tw(input int unsigned j, input int unsigned s,
                                         input int unsigned a_bit);
    int unsigned h, k;
    h = 32'd1 << s;
    k = j & (h - 32'd1);
    return k << (a_bit - 32'd1 - s);
  endfunction

endpackage

// File: rtl/fht_ctrl_dly.sv
// PIPE_LAT-deep delay line for the write-side strobe and its payload.
// Only the strobe is cleared; payload is qualified by the strobe downstream.
module fht_ctrl_dly #(
  parameter int PIPE_LAT = 3,
  parameter int W        = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic [PIPE_LAT-1:0] vld_q;
  logic [W-1:0]        dat_q [PIPE_LAT];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < PIPE_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    dat_q[0] <= dat_i;
    for (int i = 1; i < PIPE_LAT; i++) dat_q[i] <= dat_q[i-1];
  end

  assign vld_o = vld_q[PIPE_LAT-1];
  assign dat_o = dat_q[PIPE_LAT-1];

endmodule

// File: rtl/fht_but_ctrl.sv
// Stage/butterfly sequencer for the radix-2 FHT core (read/twiddle/bank issue,
// write addresses delayed by PIPE_LAT). Optional abort input: FHT_CTRL_ABORT_EN.
module fht_but_ctrl #(
  parameter int N        = 16,
  parameter int A_BIT    = $clog2(N),
  parameter int PIPE_LAT = 3
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
`ifdef FHT_CTRL_ABORT_EN
  input  logic             iABORT,
`endif
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oRD_EN,
  output logic             oRD_BANK,
  output logic [A_BIT-1:0] oADDR_X0,
  output logic [A_BIT-1:0] oADDR_X1,
  output logic [A_BIT-1:0] oADDR_X2,
  output logic [A_BIT-2:0] oTW_IDX,
  output logic             oWR_EN,
  output logic             oWR_BANK,
  output logic [A_BIT-1:0] oADDR_Y0,
  output logic [A_BIT-1:0] oADDR_Y1,
  output logic             oRES_BANK
);
  import fht_ctrl_pkg::*;

  localparam int J_W = A_BIT - 1;
  localparam int S_W = (A_BIT > 1) ? $clog2(A_BIT) : 1;
  localparam int D_W = $clog2(PIPE_LAT + 1);
  localparam int Y_W = 1 + 2 * A_BIT;

  localparam logic [J_W-1:0] J_LAST   = '1;
  localparam logic [S_W-1:0] S_LAST   = S_W'(A_BIT - 1);
  localparam logic [D_W-1:0] D_LAST   = D_W'(PIPE_LAT - 1);
  localparam logic           RES_BANK = (A_BIT % 2) == 1;

  state_e         state_q, state_d;
  logic [S_W-1:0] s_q, s_d;
  logic [J_W-1:0] j_q, j_d;
  logic [D_W-1:0] d_q, d_d;
  logic           abort_w;

  logic           rd_en, wr_bank_rd, wr_vld;
  logic [Y_W-1:0] wr_dat_in, wr_dat_out;

`ifdef FHT_CTRL_ABORT_EN
  assign abort_w = iABORT && (state_q == ST_RUN || state_q == ST_DRAIN);
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          state_d = ST_RUN;
          s_d     = '0;
          j_d     = '0;
        end
      end
      ST_RUN: begin
        j_d = j_q + 1'b1;
        if (j_q == J_LAST) begin
          state_d = ST_DRAIN;
          d_d     = '0;
        end
      end
      // Hold off the next stage until every write of this stage has landed.
      ST_DRAIN: begin
        d_d = d_q + 1'b1;
        if (d_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + 1'b1;
            j_d     = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_w) state_d = ST_IDLE;
  end

  always_comb begin
    rd_en      = (state_q == ST_RUN);
    oBUSY      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    oDONE      = (state_q == ST_DONE);
    oRD_EN     = rd_en;
    oRD_BANK   = rd_en & s_q[0];
    wr_bank_rd = rd_en & ~s_q[0];
    oADDR_X0   = '0;
    oADDR_X1   = '0;
    oADDR_X2   = '0;
    oTW_IDX    = '0;
    if (rd_en) begin
      oADDR_X0 = A_BIT'(but_x0(32'(j_q), 32'(s_q)));
      oADDR_X1 = A_BIT'(but_x1(32'(j_q), 32'(s_q)));
      oADDR_X2 = A_BIT'(but_x2(32'(j_q), 32'(s_q)));
      oTW_IDX  = J_W'(but_tw(32'(j_q), 32'(s_q), 32'(A_BIT)));
    end
  end

  assign wr_dat_in = {wr_bank_rd, oADDR_X0, oADDR_X1};

  fht_ctrl_dly #(
    .PIPE_LAT (PIPE_LAT),
    .W        (Y_W)
  ) u_dly (
    .clk_i (iCLK),
    .clr_i (iRESET | abort_w),
    .vld_i (rd_en),
    .dat_i (wr_dat_in),
    .vld_o (wr_vld),
    .dat_o (wr_dat_out)
  );

  always_comb begin
    oWR_EN   = wr_vld;
    oWR_BANK = 1'b0;
    oADDR_Y0 = '0;
    oADDR_Y1 = '0;
    if (wr_vld) begin
      oWR_BANK = wr_dat_out[Y_W-1];
      oADDR_Y0 = wr_dat_out[2*A_BIT-1:A_BIT];
      oADDR_Y1 = wr_dat_out[A_BIT-1:0];
    end
  end

  assign oRES_BANK = RES_BANK;

endmodule

// File: tb/tb_fht_but_ctrl.sv
// Directed self-checking bench for fht_but_ctrl (N=16, PIPE_LAT=3).
module tb_fht_but_ctrl;
  import fht_ctrl_pkg::*;

  localparam int N        = 16;
  localparam int A_BIT    = 4;
  localparam int PIPE_LAT = 3;

  logic             iCLK = 1'b0;
  logic             iRESET, iSTART;
`ifdef FHT_CTRL_ABORT_EN
  logic             iABORT;
`endif
  logic             oBUSY, oDONE, oRD_EN, oRD_BANK, oWR_EN, oWR_BANK, oRES_BANK;
  logic [A_BIT-1:0] oADDR_X0, oADDR_X1, oADDR_X2, oADDR_Y0, oADDR_Y1;
  logic [A_BIT-2:0] oTW_IDX;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  fht_but_ctrl #(.N(N), .A_BIT(A_BIT), .PIPE_LAT(PIPE_LAT)) dut (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .iSTART    (iSTART),
`ifdef FHT_CTRL_ABORT_EN
    .iABORT    (iABORT),
`endif
    .oBUSY     (oBUSY),
    .oDONE     (oDONE),
    .oRD_EN    (oRD_EN),
    .oRD_BANK  (oRD_BANK),
    .oADDR_X0  (oADDR_X0),
    .oADDR_X1  (oADDR_X1),
    .oADDR_X2  (oADDR_X2),
    .oTW_IDX   (oTW_IDX),
    .oWR_EN    (oWR_EN),
    .oWR_BANK  (oWR_BANK),
    .oADDR_Y0  (oADDR_Y0),
    .oADDR_Y1  (oADDR_Y1),
    .oRES_BANK (oRES_BANK)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
    cyc++;
  endtask

  // Start accepted at the edge ending cycle 0; afterwards cyc is the cycle index t0+cyc.
  task automatic start_run();
    cyc    = 0;
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
  endtask

  task automatic test_reset();
    iRESET = 1'b1;
    iSTART = 1'b1;
    step();
    step();
    n_chk++;
    if ({oBUSY, oDONE, oRD_EN, oWR_EN, oRD_BANK, oWR_BANK} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {oBUSY, oDONE, oRD_EN, oWR_EN, oRD_BANK, oWR_BANK});
    end
    n_chk++;
    if ({oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oADDR_Y0, oADDR_Y1} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr got=%h exp=0",
               {oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oADDR_Y0, oADDR_Y1});
    end
    n_chk++;
    if (oRES_BANK !== 1'b0) begin
      n_fail++;
      $display("FAIL res_bank got=%b exp=0", oRES_BANK);
    end
    iSTART = 1'b0;
    iRESET = 1'b0;
    step();
    n_chk++;
    if (oBUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins_start busy got=%b exp=0", oBUSY);
    end
  endtask

  task automatic test_full_run();
    int s, r, cw, sw, n_rd, n_wr;
    logic exp_rd, exp_wr, exp_busy, exp_done;
    logic [A_BIT-1:0] ex0, ex1, ex2;
    logic [A_BIT-2:0] etw;
    n_rd = 0;
    n_wr = 0;
    start_run();
    while (cyc <= 46) begin
      s        = (cyc - 1) / 11;
      r        = (cyc - 1) % 11;
      exp_busy = (cyc >= 1 && cyc <= 44);
      exp_rd   = exp_busy && (r < 8);
      exp_done = (cyc == 45);
      cw       = cyc - PIPE_LAT;
      exp_wr   = (cw >= 1 && cw <= 44) && (((cw - 1) % 11) < 8);
      sw       = (cw >= 1) ? (cw - 1) / 11 : 0;
      n_chk++;
      if ({oBUSY, oRD_EN, oWR_EN, oDONE} !== {exp_busy, exp_rd, exp_wr, exp_done}) begin
        n_fail++;
        $display("FAIL run_ctrl cyc=%0d busy/rd/wr/done got=%b exp=%b", cyc,
                 {oBUSY, oRD_EN, oWR_EN, oDONE}, {exp_busy, exp_rd, exp_wr, exp_done});
      end
      if (exp_rd) begin
        ex0 = A_BIT'(but_x0(r, s));
        ex1 = A_BIT'(but_x1(r, s));
        ex2 = A_BIT'(but_x2(r, s));
        etw = (A_BIT-1)'(but_tw(r, s, A_BIT));
        n_chk++;
        if ({oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oRD_BANK} !== {ex0, ex1, ex2, etw, s[0]}) begin
          n_fail++;
          $display("FAIL rd_addr cyc=%0d got=%0d/%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%0d/%b", cyc,
                   oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oRD_BANK, ex0, ex1, ex2, etw, s[0]);
        end
      end
      if (exp_wr) begin
        ex0 = A_BIT'(but_x0((cw - 1) % 11, sw));
        ex1 = A_BIT'(but_x1((cw - 1) % 11, sw));
        n_chk++;
        if ({oADDR_Y0, oADDR_Y1, oWR_BANK} !== {ex0, ex1, ~sw[0]}) begin
          n_fail++;
          $display("FAIL wr_addr cyc=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", cyc,
                   oADDR_Y0, oADDR_Y1, oWR_BANK, ex0, ex1, ~sw[0]);
        end
      end
      if (cyc == 4) begin
        n_chk++;
        if ({oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oRD_BANK} !== {4'd6, 4'd7, 4'd7, 3'd0, 1'b0}) begin
          n_fail++;
          $display("FAIL s0j3 got=%0d/%0d/%0d/%0d/%b exp=6/7/7/0/0",
                   oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oRD_BANK);
        end
      end
      if (cyc == 7) begin
        n_chk++;
        if ({oWR_EN, oWR_BANK, oADDR_Y0, oADDR_Y1} !== {1'b1, 1'b1, 4'd6, 4'd7}) begin
          n_fail++;
          $display("FAIL s0j3_wr got=%b/%b/%0d/%0d exp=1/1/6/7",
                   oWR_EN, oWR_BANK, oADDR_Y0, oADDR_Y1);
        end
      end
      if (cyc == 28) begin
        n_chk++;
        if ({oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oRD_BANK} !== {4'd9, 4'd13, 4'd15, 3'd2, 1'b0}) begin
          n_fail++;
          $display("FAIL s2j5 got=%0d/%0d/%0d/%0d/%b exp=9/13/15/2/0",
                   oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oRD_BANK);
        end
      end
      if (cyc == 37) begin
        n_chk++;
        if ({oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oRD_BANK} !== {4'd3, 4'd11, 4'd13, 3'd3, 1'b1}) begin
          n_fail++;
          $display("FAIL s3j3 got=%0d/%0d/%0d/%0d/%b exp=3/11/13/3/1",
                   oADDR_X0, oADDR_X1, oADDR_X2, oTW_IDX, oRD_BANK);
        end
      end
      if (oRD_EN === 1'b1) n_rd++;
      if (oWR_EN === 1'b1) n_wr++;
      step();
    end
    n_chk++;
    if (n_rd != 32 || n_wr != 32) begin
      n_fail++;
      $display("FAIL strobe_count rd=%0d wr=%0d exp=32/32", n_rd, n_wr);
    end
  endtask

  task automatic test_start_ignored();
    int n_done, done_at;
    n_done  = 0;
    done_at = 0;
    start_run();
    while (cyc <= 47) begin
      iSTART = (cyc == 10 || cyc == 45 || cyc == 46);
      if (oDONE === 1'b1 && cyc <= 46) begin
        n_done++;
        done_at = cyc;
      end
      if (cyc == 44 || cyc == 46) begin
        n_chk++;
        if (oBUSY !== (cyc == 44)) begin
          n_fail++;
          $display("FAIL busy_edge cyc=%0d got=%b exp=%b", cyc, oBUSY, cyc == 44);
        end
      end
      if (cyc == 47) begin
        n_chk++;
        if ({oBUSY, oRD_EN} !== 2'b11) begin
          n_fail++;
          $display("FAIL restart cyc=47 busy/rd got=%b exp=11", {oBUSY, oRD_EN});
        end
      end
      step();
    end
    iSTART = 1'b0;
    n_chk++;
    if (n_done != 1 || done_at != 45) begin
      n_fail++;
      $display("FAIL done_pulse count=%0d at=%0d exp=1 at 45", n_done, done_at);
    end
    while (oDONE !== 1'b1 && cyc < 150) step();
    n_chk++;
    if (oDONE !== 1'b1 || cyc != 91) begin
      n_fail++;
      $display("FAIL second_run_done cyc=%0d done=%b exp=91/1", cyc, oDONE);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n_bad;
    n_bad = 0;
    start_run();
    while (cyc < 19) step();
    n_chk++;
    if ({oRD_EN, oRD_BANK} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_s1_run got=%b exp=11", {oRD_EN, oRD_BANK});
    end
    iRESET = 1'b1;
    step();
    iRESET = 1'b0;
    n_chk++;
    if ({oBUSY, oDONE, oRD_EN, oWR_EN, oRD_BANK, oWR_BANK, oADDR_X0, oADDR_Y0, oADDR_Y1} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset busy=%b done=%b rd=%b wr=%b y0=%0d y1=%0d exp=all 0",
               oBUSY, oDONE, oRD_EN, oWR_EN, oADDR_Y0, oADDR_Y1);
    end
    repeat (60) begin
      step();
      if (oWR_EN !== 1'b0 || oDONE !== 1'b0 || oBUSY !== 1'b0) n_bad++;
    end
    n_chk++;
    if (n_bad != 0) begin
      n_fail++;
      $display("FAIL after_reset_activity got=%0d cycles exp=0", n_bad);
    end
  endtask

`ifdef FHT_CTRL_ABORT_EN
  task automatic test_abort();
    int n_bad;
    int ab_cyc [2] = '{11, 6};
    for (int a = 0; a < 2; a++) begin
      n_bad = 0;
      start_run();
      while (cyc < ab_cyc[a]) step();
      n_chk++;
      if ({oBUSY, oWR_EN} !== 2'b11) begin
        n_fail++;
        $display("FAIL pre_abort cyc=%0d busy/wr got=%b exp=11", cyc, {oBUSY, oWR_EN});
      end
      iABORT = 1'b1;
      step();
      iABORT = 1'b0;
      n_chk++;
      if ({oBUSY, oRD_EN, oWR_EN, oDONE} !== 4'b0) begin
        n_fail++;
        $display("FAIL abort cyc=%0d busy/rd/wr/done got=%b exp=0000", cyc,
                 {oBUSY, oRD_EN, oWR_EN, oDONE});
      end
      repeat (50) begin
        step();
        if (oWR_EN !== 1'b0 || oDONE !== 1'b0 || oBUSY !== 1'b0) n_bad++;
      end
      n_chk++;
      if (n_bad != 0) begin
        n_fail++;
        $display("FAIL after_abort_activity got=%0d cycles exp=0", n_bad);
      end
    end
  endtask
`endif

  initial begin
    iRESET = 1'b1;
    iSTART = 1'b0;
`ifdef FHT_CTRL_ABORT_EN
    iABORT = 1'b0;
`endif
    test_reset();
    test_full_run();
    test_start_ignored();
    test_reset_mid();
`ifdef FHT_CTRL_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
